// File: rtl/cube_vertex_sequencer.sv
// Frame-level cube corner sequencer: walks the 8 corners through the transformer and collects
// the projected points into a double-buffered vertex table that swaps atomically at frame end.
module cube_vertex_sequencer #(
  parameter int BOX_SIZE = 600 <<< 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iFrameStart,
  input  logic signed [15:0] iAlpha,
  input  logic signed [15:0] iBeta,
  input  logic signed [15:0] iGamma,
  output logic signed [15:0] oAlpha,
  output logic signed [15:0] oBeta,
  output logic signed [15:0] oGamma,
  output logic               oXformStart,
  output logic signed [15:0] oX,
  output logic signed [15:0] oY,
  output logic signed [15:0] oZ,
  input  logic               iXformDone,
  input  logic signed [15:0] iPX,
  input  logic signed [15:0] iPY,
  input  logic [2:0]         iRdAddr,
  output logic signed [15:0] oRdX,
  output logic signed [15:0] oRdY,
  output logic               oBusy,
  output logic               oFrameDone
);

  localparam logic signed [15:0] H = 16'(BOX_SIZE >>> 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StSwap} state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic               front_q, front_d;
  logic signed [15:0] alpha_q, beta_q, gamma_q;
  logic signed [15:0] bank_x [2][8];
  logic signed [15:0] bank_y [2][8];
  logic               accept;
  logic               capture;
  logic               back_sel;

  assign accept   = (state_q == StIdle) && iFrameStart;
  assign capture  = (state_q == StWait) && iXformDone;
  assign back_sel = ~front_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    front_d = front_q;
    unique case (state_q)
      StIdle: begin
        if (iFrameStart) begin
          idx_d   = 3'd0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (iXformDone) begin
          if (idx_q == 3'd7) begin
            // Toggling here makes the new frame readable during the SWAP cycle itself.
            front_d = ~front_q;
            state_d = StSwap;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StIssue;
          end
        end
      end
      StSwap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      front_q <= 1'b0;
      alpha_q <= '0;
      beta_q  <= '0;
      gamma_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 8; i++) begin
          bank_x[b][i] <= '0;
          bank_y[b][i] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      front_q <= front_d;
      if (accept) begin
        alpha_q <= iAlpha;
        beta_q  <= iBeta;
        gamma_q <= iGamma;
      end
      if (capture) begin
        bank_x[back_sel][idx_q] <= iPX;
        bank_y[back_sel][idx_q] <= iPY;
      end
    end
  end

  assign oAlpha      = alpha_q;
  assign oBeta       = beta_q;
  assign oGamma      = gamma_q;
  assign oXformStart = (state_q == StIssue);
  assign oFrameDone  = (state_q == StSwap);
  assign oBusy       = (state_q != StIdle);
  assign oX          = idx_q[0] ? H : -H;
  assign oY          = idx_q[1] ? H : -H;
  assign oZ          = idx_q[2] ? H : -H;
  assign oRdX        = bank_x[front_q][iRdAddr];
  assign oRdY        = bank_y[front_q][iRdAddr];

endmodule

// File: tb/tb_cube_vertex_sequencer.sv
// Directed bench for cube_vertex_sequencer with a cycle-stepped transformer model.
module tb_cube_vertex_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               iFrameStart;
  logic signed [15:0] iAlpha, iBeta, iGamma;
  logic signed [15:0] oAlpha, oBeta, oGamma;
  logic               oXformStart;
  logic signed [15:0] oX, oY, oZ;
  logic               iXformDone;
  logic signed [15:0] iPX, iPY;
  logic [2:0]         iRdAddr;
  logic signed [15:0] oRdX, oRdY;
  logic               oBusy;
  logic               oFrameDone;

  cube_vertex_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .iFrameStart(iFrameStart),
    .iAlpha     (iAlpha),
    .iBeta      (iBeta),
    .iGamma     (iGamma),
    .oAlpha     (oAlpha),
    .oBeta      (oBeta),
    .oGamma     (oGamma),
    .oXformStart(oXformStart),
    .oX         (oX),
    .oY         (oY),
    .oZ         (oZ),
    .iXformDone (iXformDone),
    .iPX        (iPX),
    .iPY        (iPY),
    .iRdAddr    (iRdAddr),
    .oRdX       (oRdX),
    .oRdY       (oRdY),
    .oBusy      (oBusy),
    .oFrameDone (oFrameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int z;
  } corner_t;

  typedef struct {
    logic [2:0] addr;
    int         x;
    int         y;
  } rd_vec_t;

  int      checks = 0;
  int      errors = 0;
  corner_t corners [8];
  rd_vec_t rd_vec  [8];
  int      fx [8];
  int      fy [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    iFrameStart = 1'b0;
    iXformDone  = 1'b0;
    iPX         = 16'sh7777;
    iPY         = 16'sh6666;
  endtask

  // One frame; corner k returns (base+10k+1, -(base+10k+2)). Starts and ends at a negedge in IDLE.
  task automatic run_frame(input int base, input int lat_def, input int stall_k,
                           input int stall_lat, input bit inject);
    int lat [8];
    int exp_issue [8];
    int nx [8];
    int ny [8];
    int done_c, k, due, pend_k, pulses, cur, a0, b0, g0;
    bit exp_start, in_wait;
    for (int i = 0; i < 8; i++) begin
      lat[i] = (i == stall_k) ? stall_lat : lat_def;
      exp_issue[i] = (i == 0) ? 1 : exp_issue[i-1] + lat[i-1] + 1;
      nx[i] = base + 10 * i + 1;
      ny[i] = -(base + 10 * i + 2);
    end
    done_c = exp_issue[7] + lat[7] + 1;
    a0 = 100 + base;
    b0 = 200 + base;
    g0 = 300 + base;
    k = 0;
    due = -1;
    pend_k = 0;
    pulses = 0;
    for (int c = 0; c <= done_c + 2; c++) begin
      iRdAddr = 3'(c % 8);
      #1;
      if (c == 0) begin
        chk("busy_pre", int'(oBusy), 0);
      end else begin
        exp_start = 1'b0;
        in_wait   = 1'b0;
        cur       = -1;
        for (int i = 0; i < 8; i++) begin
          if (exp_issue[i] == c) exp_start = 1'b1;
          if (exp_issue[i] + 1 == c) in_wait = 1'b1;
          if (exp_issue[i] <= c) cur = i;
        end
        chk($sformatf("start@%0d", c), int'(oXformStart), int'(exp_start));
        chk($sformatf("frame_done@%0d", c), int'(oFrameDone), int'(c == done_c));
        chk($sformatf("busy@%0d", c), int'(oBusy), int'(c <= done_c));
        chk($sformatf("alpha@%0d", c), int'(oAlpha), a0);
        chk($sformatf("beta@%0d", c), int'(oBeta), b0);
        chk($sformatf("gamma@%0d", c), int'(oGamma), g0);
        if (c <= done_c && cur >= 0) begin
          chk($sformatf("x@%0d", c), int'(oX), corners[cur].x);
          chk($sformatf("y@%0d", c), int'(oY), corners[cur].y);
          chk($sformatf("z@%0d", c), int'(oZ), corners[cur].z);
        end
        chk($sformatf("rdx@%0d", c), int'(oRdX), (c < done_c) ? fx[c % 8] : nx[c % 8]);
        chk($sformatf("rdy@%0d", c), int'(oRdY), (c < done_c) ? fy[c % 8] : ny[c % 8]);
      end
      if (oXformStart) begin
        pulses++;
        if (k < 8) begin
          due = c + lat[k];
          pend_k = k;
          k++;
        end
      end
      idle_inputs();
      if (c == 0) begin
        iFrameStart = 1'b1;
        iAlpha = 16'(a0);
        iBeta  = 16'(b0);
        iGamma = 16'(g0);
      end else if (inject) begin
        iAlpha = 16'($urandom);
        iBeta  = 16'($urandom);
        iGamma = 16'($urandom);
      end
      if (c == due) begin
        iXformDone = 1'b1;
        iPX = 16'(nx[pend_k]);
        iPY = 16'(ny[pend_k]);
      end
      if (inject) begin
        if (c > 0 && (exp_start || c == done_c || (in_wait && c != due))) iFrameStart = 1'b1;
        if (exp_start || c == 0 || c == done_c + 1) iXformDone = 1'b1;
      end
      @(negedge clk);
    end
    idle_inputs();
    chk("pulse_count", pulses, 8);
    for (int i = 0; i < 8; i++) begin
      fx[i] = nx[i];
      fy[i] = ny[i];
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, int'(oBusy), 0);
    chk({tag, "_start"}, int'(oXformStart), 0);
    chk({tag, "_fdone"}, int'(oFrameDone), 0);
    chk({tag, "_alpha"}, int'(oAlpha), 0);
    chk({tag, "_beta"}, int'(oBeta), 0);
    chk({tag, "_gamma"}, int'(oGamma), 0);
    chk({tag, "_x"}, int'(oX), -2400);
    chk({tag, "_y"}, int'(oY), -2400);
    chk({tag, "_z"}, int'(oZ), -2400);
    for (int a = 0; a < 8; a++) begin
      iRdAddr = 3'(a);
      #1;
      chk($sformatf("%s_rdx%0d", tag, a), int'(oRdX), 0);
      chk($sformatf("%s_rdy%0d", tag, a), int'(oRdY), 0);
    end
  endtask

  initial begin
    corners[0] = '{-2400, -2400, -2400};
    corners[1] = '{ 2400, -2400, -2400};
    corners[2] = '{-2400,  2400, -2400};
    corners[3] = '{ 2400,  2400, -2400};
    corners[4] = '{-2400, -2400,  2400};
    corners[5] = '{ 2400, -2400,  2400};
    corners[6] = '{-2400,  2400,  2400};
    corners[7] = '{ 2400,  2400,  2400};
    rd_vec[0] = '{3'd0,  1,  -2};
    rd_vec[1] = '{3'd1, 11, -12};
    rd_vec[2] = '{3'd2, 21, -22};
    rd_vec[3] = '{3'd3, 31, -32};
    rd_vec[4] = '{3'd4, 41, -42};
    rd_vec[5] = '{3'd5, 51, -52};
    rd_vec[6] = '{3'd6, 61, -62};
    rd_vec[7] = '{3'd7, 71, -72};
    for (int i = 0; i < 8; i++) begin
      fx[i] = 0;
      fy[i] = 0;
    end

    rst = 1'b1;
    iAlpha = 16'sd0;
    iBeta = 16'sd0;
    iGamma = 16'sd0;
    iRdAddr = 3'd0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");
    @(negedge clk);

    // Single frame, then readback against the hand-computed table.
    run_frame(0, 3, -1, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      iRdAddr = rd_vec[i].addr;
      #1;
      chk($sformatf("rb_x%0d", i), int'(oRdX), rd_vec[i].x);
      chk($sformatf("rb_y%0d", i), int'(oRdY), rd_vec[i].y);
    end
    @(negedge clk);

    // Second frame exercises the double buffer; third injects ignored inputs.
    run_frame(1000, 3, -1, 0, 1'b0);
    run_frame(2000, 3, -1, 0, 1'b1);
    // Corner 2 done arrives 51 cycles after its start.
    run_frame(3000, 3, 2, 51, 1'b0);

    // Reset after corner 3 is captured, then a late done in IDLE.
    for (int c = 0; c <= 16; c++) begin
      idle_inputs();
      if (c == 0) iFrameStart = 1'b1;
      if (c > 0 && c % 4 == 0) begin
        iXformDone = 1'b1;
        iPX = 16'(5000 + 10 * (c / 4 - 1) + 1);
        iPY = 16'(-(5000 + 10 * (c / 4 - 1) + 2));
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    chk("pre_rst_busy", int'(oBusy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_busy", int'(oBusy), 0);
    iXformDone = 1'b1;
    iPX = 16'sd1234;
    iPY = 16'sd4321;
    @(negedge clk);
    idle_inputs();
    check_reset_state("midrst");
    for (int i = 0; i < 8; i++) begin
      fx[i] = 0;
      fy[i] = 0;
    end
    @(negedge clk);
    run_frame(4000, 2, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/cube_vertex_sequencer.md
# cube_vertex_sequencer

Frame-level front end of the 3D pipeline, directly upstream of the rotate-and-project transformer. On each frame request it latches the rotation angles, walks the 8 cube corners (±BOX_SIZE/2 on every axis) one at a time, and pulses the transformer's start for each corner. It captures each projected (X, Y) into a double-buffered 8-entry vertex table. The table is swapped atomically at frame end, so the downstream edge/line stage always reads a complete, consistent frame.

## Interface
- BOX_SIZE, 600 <<< 3 (4800), cube edge length in model units; corner magnitude H = BOX_SIZE >>> 1 (2400).
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- iFrameStart  in  1  frame request; sampled only in IDLE.
- iAlpha, iBeta, iGamma  in  16 signed  rotation angles; latched at frame accept.
- oAlpha, oBeta, oGamma  out  16 signed  latched angles to transformer; stable for the whole frame.
- oXformStart  out  1  one-cycle start pulse to transformer, one per corner.
- oX, oY, oZ  out  16 signed  current corner coordinates to transformer.
- iXformDone  in  1  transformer done; iPX/iPY are valid in the same cycle.
- iPX, iPY  in  16 signed  projected screen coordinates from transformer.
- iRdAddr  in  3  read address into the front (displayed) buffer.
- oRdX, oRdY  out  16 signed  combinational read of front buffer[iRdAddr].
- oBusy  out  1  high whenever state ≠ IDLE.
- oFrameDone  out  1  one-cycle pulse; new frame is visible on the read port in this same cycle.

## Operation
- States: IDLE, ISSUE, WAIT, SWAP.
- IDLE, with iFrameStart=1:
  - latch the three angles; idx←0; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - oXformStart=1 for exactly this cycle; go to WAIT.
  - iXformDone is ignored in this state, so transformer latency must be ≥1 cycle.
- WAIT, with iXformDone=1:
  - write back buffer[idx] ← {iPX, iPY}.
  - If idx==7: toggle front-select and go to SWAP.
  - Else: idx←idx+1 and go to ISSUE.
  - With iXformDone=0: stay in WAIT, with no timeout.
- SWAP:
  - oFrameDone=1; go to IDLE.
  - The front-select toggle took effect on entry, so the read port already shows the new frame.
- Corner encoding from idx[2:0]:
  - oX = idx[0] ? +H : −H
  - oY = idx[1] ? +H : −H
  - oZ = idx[2] ? +H : −H
  - idx 0 = (−H,−H,−H); idx 7 = (+H,+H,+H).
- oX/oY/oZ are decoded from the idx register only, so they hold stable through ISSUE and WAIT.
- Buffers: two banks of 8×{16,16}.
  - Writes go only to the bank not selected as front.
  - Reads come only from the front bank.
  - The front bank is never modified mid-frame.
- iFrameStart in ISSUE, WAIT or SWAP is ignored and not queued.
- iXformDone in IDLE, ISSUE or SWAP is ignored: no write, no state change.
- Angle inputs changing mid-frame have no effect until the next accepted iFrameStart.
- No arithmetic beyond the constant ±H; H must fit in 16 signed bits (BOX_SIZE ≤ 65534).

## Timing
- All control outputs are derived from registered state: oXformStart, oFrameDone, oBusy, oX/oY/oZ, oAlpha/oBeta/oGamma.
- oRdX/oRdY are the only combinational path (iRdAddr → mux).
- Cycle numbering: iFrameStart is sampled high in IDLE at cycle 0.
  - ISSUE (oXformStart=1) for corner k falls at cycle 1 + k·(L+1).
  - L = cycles from oXformStart high to iXformDone high.
  - SWAP/oFrameDone falls at cycle 8·(L+1)+1; IDLE follows at 8·(L+1)+2.
- oBusy rises in cycle 1 and falls in the cycle after SWAP.
- Earliest next accepted iFrameStart is the first IDLE cycle.
- Reset, synchronous, any state, effective at the next edge:
  - state IDLE, idx 0, front-select 0.
  - Both banks cleared to 0; angle latches 0.
  - oXformStart=0, oFrameDone=0, oBusy=0.
  - oX/oY/oZ = −H (idx 0).
  - oRdX/oRdY read 0 for every address.

## Test plan
- **Reset values:** assert rst 2 cycles → oBusy=0, oXformStart=0, oFrameDone=0, oAlpha/oBeta/oGamma=0, oX=oY=oZ=−2400, oRdX/oRdY=0 for iRdAddr 0..7.
- **Single frame:**
  - Stimulus: model transformer with L=3 returning iPX=10k+1, iPY=−(10k+2); iAlpha/iBeta/iGamma=100/200/300; pulse iFrameStart.
  - Required: exactly 8 oXformStart pulses at cycles 1, 5, …, 29; corner 5 = (+2400,−2400,+2400); oFrameDone only at cycle 33; readback addr k = (10k+1, −(10k+2)); oAlpha/oBeta/oGamma = 100/200/300 throughout.
- **Double buffer:** run frame 1, then frame 2 with new values → read port shows frame-1 values in every cycle up to cycle 32 of frame 2, and frame-2 values from the oFrameDone cycle on.
- **Ignored inputs:** iFrameStart pulsed in ISSUE, WAIT and SWAP; angles changed mid-frame; iXformDone pulsed in IDLE and ISSUE → no extra frame, no extra writes, pulse count and timing identical to the single-frame test, angle outputs unchanged.
- **Stall:** hold iXformDone low 50 cycles after corner 2's start → oXformStart stays low, oX/oY/oZ hold corner 2 = (−2400,+2400,−2400), oBusy=1; frame completes normally after done.
- **Reset mid-frame:** assert rst after corner 3 is captured, then deliver a late iXformDone → IDLE state, all reset values restored, both banks read 0, late done causes no write; next frame runs from corner 0.
